// File: rtl/mxint8_pkg.sv
// Shared widths, constants and FSM state type for the MXINT8 -> FP32 block decoder.
package mxint8_pkg;
    localparam int ELEM_W             = 8;
    localparam int SCALE_W            = 8;
    localparam int FP32_W             = 32;
    localparam int FP32_EXP_W         = 8;
    localparam int FP32_FRAC_W        = 23;
    localparam int BLOCK_SIZE_DEFAULT = 32;
    localparam int E8M0_BIAS          = 127;
    localparam int FP32_BIAS          = 127;
    localparam int ELEM_FRAC_BITS     = 6;

    localparam logic [FP32_W-1:0]     FP32_QNAN    = 32'h7FC0_0000;
    localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;
    localparam logic [SCALE_W-1:0]    E8M0_NAN     = 8'hFF;

    typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/mxint8_elem_to_fp32.sv
// Combinational exact conversion of one MXINT8 element (1.6 fixed point) plus E8M0 scale to FP32.
// MXINT8_BD_SUBNORM_EN selects exact subnormals; otherwise tiny results flush to signed zero.
module mxint8_elem_to_fp32
    import mxint8_pkg::*;
(
    input  logic [SCALE_W-1:0] scale,
    input  logic [ELEM_W-1:0]  elem,
    output logic [FP32_W-1:0]  fp32,
    output logic               overflow
);
    logic                   sign;
    logic [ELEM_W-1:0]      mag;
    logic [2:0]             lead;
    logic signed [9:0]      exp_biased;
    logic [FP32_FRAC_W-1:0] frac_norm;
`ifdef MXINT8_BD_SUBNORM_EN
    logic [FP32_FRAC_W-1:0] frac_sub;
`endif

    // -128 negates to 0x80, which reads correctly as unsigned 128
    assign sign = elem[ELEM_W-1];
    assign mag  = sign ? (~elem + 8'd1) : elem;

    always_comb begin
        lead = '0;
        for (int i = 0; i < ELEM_W; i++) begin
            if (mag[i]) lead = 3'(i);
        end
    end

    assign exp_biased = $signed({2'b00, scale}) + $signed({7'd0, lead})
                      + 10'(FP32_BIAS - E8M0_BIAS - ELEM_FRAC_BITS);

    // Shifting the leading one to bit 23 drops it out of the 23-bit field
    assign frac_norm = FP32_FRAC_W'(mag) << (5'(FP32_FRAC_W) - {2'b00, lead});

`ifdef MXINT8_BD_SUBNORM_EN
    assign frac_sub = FP32_FRAC_W'(mag) << (scale + 8'(FP32_FRAC_W - ELEM_FRAC_BITS - 1));
`endif

    always_comb begin
        fp32     = '0;
        overflow = 1'b0;
        if (scale == E8M0_NAN) begin
            fp32 = FP32_QNAN;
        end else if (elem == '0) begin
            fp32 = '0;
        end else if (exp_biased >= 10'sd255) begin
            fp32     = {sign, FP32_EXP_MAX, {FP32_FRAC_W{1'b0}}};
            overflow = 1'b1;
        end else if (exp_biased >= 10'sd1) begin
            fp32 = {sign, exp_biased[FP32_EXP_W-1:0], frac_norm};
        end else begin
`ifdef MXINT8_BD_SUBNORM_EN
            fp32 = {sign, {FP32_EXP_W{1'b0}}, frac_sub};
`else
            fp32 = {sign, {(FP32_W-1){1'b0}}};
`endif
        end
    end
endmodule

// File: rtl/mxint8_to_fp32_bd.sv
// MXINT8 block decoder: captures one block, streams BLOCK_SIZE FP32 elements under valid/ready.
// Optional macro MXINT8_BD_SUBNORM_EN enables exact subnormal outputs in the element converter.
module mxint8_to_fp32_bd
    import mxint8_pkg::*;
#(
    parameter  int BLOCK_SIZE = BLOCK_SIZE_DEFAULT,
    localparam int IDX_W      = $clog2(BLOCK_SIZE)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [SCALE_W-1:0] i_scale,
    input  logic [ELEM_W-1:0]  i_mxint8_elements [BLOCK_SIZE-1:0],
    output logic               o_valid,
    input  logic               i_ready,
    output logic [FP32_W-1:0]  o_float32,
    output logic [IDX_W-1:0]   o_index,
    output logic               o_last,
    output logic               o_overflow
);
    state_t             state, state_next;
    logic               accept;
    logic [SCALE_W-1:0] scale_reg;
    logic [ELEM_W-1:0]  elems_reg [BLOCK_SIZE-1:0];
    logic               load;
    logic [IDX_W-1:0]   load_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [SCALE_W-1:0] conv_scale;
    logic [ELEM_W-1:0]  conv_elem;
    logic [FP32_W-1:0]  conv_fp32;
    logic               conv_overflow;

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == STREAM);
    assign accept   = o_ready && i_valid;
    assign next_idx = o_last ? '0 : o_index + IDX_W'(1);

    always_ff @(posedge i_clk) begin
        if (accept) begin
            scale_reg <= i_scale;
            elems_reg <= i_mxint8_elements;
        end
    end

    // Element 0 converts straight from the inputs so it is ready the cycle after accept
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_idx   = o_index;
        conv_scale = scale_reg;
        conv_elem  = elems_reg[next_idx];
        case (state)
            IDLE: begin
                conv_scale = i_scale;
                conv_elem  = i_mxint8_elements[0];
                if (i_valid) begin
                    state_next = STREAM;
                    load       = 1'b1;
                    load_idx   = '0;
                end
            end
            STREAM: begin
                if (i_ready) begin
                    if (o_last) begin
                        state_next = IDLE;
                    end else begin
                        load     = 1'b1;
                        load_idx = next_idx;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mxint8_elem_to_fp32 u_conv (
        .scale    (conv_scale),
        .elem     (conv_elem),
        .fp32     (conv_fp32),
        .overflow (conv_overflow)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_float32  <= '0;
            o_index    <= '0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                o_float32  <= conv_fp32;
                o_index    <= load_idx;
                o_last     <= (load_idx == IDX_W'(BLOCK_SIZE - 1));
                o_overflow <= conv_overflow;
            end
        end
    end
endmodule

// File: tb/tb_mxint8_to_fp32_bd.sv
// Directed bench for the MXINT8 block decoder: vector table, backpressure and mid-block reset.
module tb_mxint8_to_fp32_bd;
    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_scale;
    logic [7:0]  i_mxint8_elements [31:0];
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_float32;
    logic [4:0]  o_index;
    logic        o_last;
    logic        o_overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  blk [31:0];
    logic [7:0]  blk_scale;
    logic [31:0] exp_fp [32];
    logic        exp_ovf [32];

    typedef struct packed {
        logic [7:0]  scale;
        logic [7:0]  elem;
        logic [31:0] fp;
        logic        ovf;
    } vec_t;
    vec_t vecs [20];

`ifdef MXINT8_BD_SUBNORM_EN
    localparam logic [31:0] SUB_P   = 32'h0040_0000;
    localparam logic [31:0] SUB_N1  = 32'h8001_0000;
    localparam logic [31:0] SUB_N64 = 32'h8040_0000;
`else
    localparam logic [31:0] SUB_P   = 32'h0000_0000;
    localparam logic [31:0] SUB_N1  = 32'h8000_0000;
    localparam logic [31:0] SUB_N64 = 32'h8000_0000;
`endif

    always #5 clk = ~clk;

    mxint8_to_fp32_bd #(.BLOCK_SIZE(32)) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_scale           (i_scale),
        .i_mxint8_elements (i_mxint8_elements),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_float32         (o_float32),
        .o_index           (o_index),
        .o_last            (o_last),
        .o_overflow        (o_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (o_ready !== 1'b1 && t < 64) begin
            tick();
            t++;
        end
        check($sformatf("%s ready", tag), 48'(o_ready), 48'd1);
    endtask

    task automatic fill(input logic [7:0] e, input logic [31:0] fp, input logic ovf);
        for (int k = 0; k < 32; k++) begin
            blk[k]     = e;
            exp_fp[k]  = fp;
            exp_ovf[k] = ovf;
        end
    endtask

    // Accept blk/blk_scale, then stream with i_ready high and compare every element
    task automatic run_block(input string tag);
        wait_ready(tag);
        i_scale           = blk_scale;
        i_mxint8_elements = blk;
        i_valid           = 1'b1;
        i_ready           = 1'b1;
        tick();
        i_valid = 1'b0;
        i_scale = ~blk_scale;
        for (int k = 0; k < 32; k++) i_mxint8_elements[k] = ~blk[k];
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s elem%0d", tag, k),
                  48'({o_valid, o_index, o_last, o_overflow, o_float32}),
                  48'({1'b1, 5'(k), (k == 31), exp_ovf[k], exp_fp[k]}));
            tick();
        end
        check($sformatf("%s idle", tag), 48'({o_valid, o_ready}), 48'b01);
        $display("block %s scale=%h done", tag, blk_scale);
    endtask

    initial begin
        vecs[0]  = '{8'd127, 8'h40, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{8'd127, 8'hC0, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{8'd127, 8'h00, 32'h0000_0000, 1'b0};
        vecs[3]  = '{8'd127, 8'h01, 32'h3C80_0000, 1'b0};
        vecs[4]  = '{8'd127, 8'h80, 32'hC000_0000, 1'b0};
        vecs[5]  = '{8'd127, 8'h7F, 32'h3FFE_0000, 1'b0};
        vecs[6]  = '{8'd130, 8'h9B, 32'hC14A_0000, 1'b0};
        vecs[7]  = '{8'hFF,  8'h80, 32'h7FC0_0000, 1'b0};
        vecs[8]  = '{8'hFF,  8'h00, 32'h7FC0_0000, 1'b0};
        vecs[9]  = '{8'd254, 8'h80, 32'hFF80_0000, 1'b1};
        vecs[10] = '{8'd254, 8'h7F, 32'h7F7E_0000, 1'b0};
        vecs[11] = '{8'd253, 8'h80, 32'hFF00_0000, 1'b0};
        vecs[12] = '{8'd254, 8'h01, 32'h7C00_0000, 1'b0};
        vecs[13] = '{8'd7,   8'h01, 32'h0080_0000, 1'b0};
        vecs[14] = '{8'd0,   8'h80, 32'h8080_0000, 1'b0};
        vecs[15] = '{8'd0,   8'h40, SUB_P,         1'b0};
        vecs[16] = '{8'd0,   8'hFF, SUB_N1,        1'b0};
        vecs[17] = '{8'd6,   8'h01, SUB_P,         1'b0};
        vecs[18] = '{8'd1,   8'h20, SUB_P,         1'b0};
        vecs[19] = '{8'd0,   8'hC0, SUB_N64,       1'b0};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_scale = '0;
        for (int k = 0; k < 32; k++) i_mxint8_elements[k] = '0;
        tick();
        tick();
        check("reset", 48'({o_valid, o_ready, o_index, o_last, o_overflow, o_float32}),
              48'({1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'd0}));
        i_rst = 1'b0;
        tick();

        // Mixed block: e0..e4 from the plan, rest 1.0
        blk_scale = 8'd127;
        fill(8'h40, 32'h3F80_0000, 1'b0);
        blk[1] = 8'hC0; exp_fp[1] = 32'hBF80_0000;
        blk[2] = 8'h00; exp_fp[2] = 32'h0000_0000;
        blk[3] = 8'h01; exp_fp[3] = 32'h3C80_0000;
        blk[4] = 8'h80; exp_fp[4] = 32'hC000_0000;
        run_block("mixed");

        // Top of range in one block
        blk_scale = 8'd254;
        fill(8'h7F, 32'h7F7E_0000, 1'b0);
        blk[0] = 8'h80; exp_fp[0] = 32'hFF80_0000; exp_ovf[0] = 1'b1;
        run_block("top");

        for (int v = 0; v < 20; v++) begin
            blk_scale = vecs[v].scale;
            fill(vecs[v].elem, vecs[v].fp, vecs[v].ovf);
            run_block($sformatf("vec%0d", v));
        end

        blk_scale = 8'hFF;
        fill(8'h00, 32'h7FC0_0000, 1'b0);
        for (int k = 0; k < 32; k++) blk[k] = 8'($urandom_range(0, 255));
        run_block("nan_rand");

        // Backpressure at index 5 with the next block already pending
        wait_ready("bp");
        for (int k = 0; k < 32; k++) i_mxint8_elements[k] = 8'h40;
        i_mxint8_elements[5] = 8'hC0;
        i_mxint8_elements[6] = 8'h01;
        i_scale = 8'd127;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) i_mxint8_elements[k] = 8'h80;
        for (int k = 0; k < 5; k++) tick();
        check("bp idx5", 48'({o_valid, o_index, o_float32}), 48'({1'b1, 5'd5, 32'hBF80_0000}));
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp stall%0d", c), 48'({o_valid, o_ready, o_index, o_float32}),
                  48'({1'b1, 1'b0, 5'd5, 32'hBF80_0000}));
        end
        i_ready = 1'b1;
        tick();
        check("bp idx6", 48'({o_valid, o_index, o_float32}), 48'({1'b1, 5'd6, 32'h3C80_0000}));
        for (int k = 7; k <= 31; k++) tick();
        check("bp idx31", 48'({o_valid, o_index, o_last, o_float32}),
              48'({1'b1, 5'd31, 1'b1, 32'h3F80_0000}));
        tick();
        check("bp gap", 48'({o_valid, o_ready}), 48'b01);
        tick();
        check("bp blk2 e0", 48'({o_valid, o_index, o_float32}), 48'({1'b1, 5'd0, 32'hC000_0000}));
        i_valid = 1'b0;
        begin
            int t = 0;
            while (!(o_valid && o_last) && t < 40) begin
                tick();
                t++;
            end
        end
        tick();
        check("bp drained", 48'({o_valid, o_ready}), 48'b01);
        $display("block bp done");

        // Reset at index 10
        wait_ready("rst");
        for (int k = 0; k < 32; k++) i_mxint8_elements[k] = 8'h7F;
        i_scale = 8'd127;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("rst idx10", 48'({o_valid, o_index}), 48'({1'b1, 5'd10}));
        i_rst = 1'b1;
        #1;
        check("rst async", 48'({o_valid, o_ready, o_index, o_float32}), 48'({1'b0, 1'b1, 5'd0, 32'd0}));
        tick();
        i_rst = 1'b0;
        #1;
        check("rst release", 48'({o_valid, o_ready}), 48'b01);
        blk_scale = 8'd130;
        fill(8'h9B, 32'hC14A_0000, 1'b0);
        run_block("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mxint8_to_fp32_bd.md
# mxint8_to_fp32_bd

Block decoder for OCP MXINT8. It accepts one MX block: an E8M0 shared scale and `BLOCK_SIZE` int8 elements, each in 1.6 two's-complement fixed point. It then streams out the exact FP32 value of each element, one per cycle, under a valid/ready handshake. It sits on the read side of MX storage and feeds FP32 consumers, so it is the inverse of the FP32→MXINT8 encoder.

## Interface
- `BLOCK_SIZE`, default 32: elements per block.
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: input block valid.
- `o_ready` out 1: block accepted on `i_valid && o_ready`.
- `i_scale` in 8: E8M0 shared scale, bias 127; 0xFF means NaN.
- `i_mxint8_elements[BLOCK_SIZE-1:0]` in 8 each: signed elements; value = e/64 · 2^(scale−127).
- `o_valid` out 1: output element valid.
- `i_ready` in 1: downstream accepts on `o_valid && i_ready`.
- `o_float32` out 32: decoded element.
- `o_index` out $clog2(BLOCK_SIZE): element index of `o_float32`.
- `o_last` out 1: high when `o_index == BLOCK_SIZE-1`.
- `o_overflow` out 1: current element saturated to ±Inf.

## Operation
- FSM states:
  - IDLE: `o_ready`=1. On accept, capture the scale and all elements, set idx=0, go to STREAM.
  - STREAM: `o_ready`=0, so `i_valid` is ignored. On output handshake, if idx==BLOCK_SIZE−1 go to IDLE; otherwise idx++.
- Output register is loaded from the converter on entry to STREAM and on each non-final handshake. It holds while `o_valid && !i_ready`.
- Per-element conversion, applied in priority order:
  - scale==0xFF: output 0x7FC00000 for every element, with `o_overflow`=0.
  - e==0: output 0x00000000.
  - Otherwise: sign=e[7]; mag=|e| in 8 bits (−128→128); p = leading-one position (0..7).
  - Biased exponent E = scale + p − 6, computed in 10-bit signed.
  - E ≥ 255 (only scale 254 with e=−128): output ±Inf (exponent 0xFF, fraction 0) and set `o_overflow`=1.
  - 1 ≤ E ≤ 254: exponent field = E; fraction = mag with the leading one removed, left-aligned to 23 bits.
  - E ≤ 0: output a subnormal, fraction = mag << (scale+16). This is handled per Configuration.
- All conversions are exact. No rounding path exists.
- Reset values: `o_valid`=0, `o_float32`=0, `o_index`=0, `o_last`=0, `o_overflow`=0, state=IDLE, so `o_ready`=1 after reset release.
- Reset during STREAM discards the block. `o_valid` drops asynchronously. The next block starts at index 0.

## Timing
- A block accepted on the edge at cycle T gives element 0 valid in cycle T+1.
- With `i_ready` held high, element k is valid in cycle T+1+k.
- `o_ready` rises in the cycle after the last handshake, so back-to-back blocks cost BLOCK_SIZE+1 cycles each.
- `o_index`, `o_last` and `o_overflow` are registered alongside `o_float32` and change only on load.
- Inputs are sampled only at the accept edge. Changes to `i_scale`/`i_mxint8_elements` during STREAM have no effect.

## Configuration
- `MXINT8_BD_SUBNORM_EN` defined: E ≤ 0 produces the exact subnormal.
- Not defined: E ≤ 0 flushes to signed zero, {sign, 31'b0}, and the subnormal shifter is removed.

## Structure
- Package `mxint8_pkg` holds:
  - widths (element 8, scale 8, FP32 field widths), `BLOCK_SIZE` default, E8M0 bias 127, element fraction bits 6;
  - constants `FP32_QNAN`=0x7FC00000, `FP32_EXP_MAX`=0xFF;
  - FSM state enum {IDLE, STREAM}.
- Sub-module `mxint8_elem_to_fp32`: purely combinational. Takes scale and element; produces FP32 and overflow. It contains the leading-one detector, exponent math and subnormal shifter.
- The top level contains the block capture registers, FSM, index counter and output register.

## Test plan
- Exact values: scale 127 with e0..e4 = 0x40, 0xC0, 0x00, 0x01, 0x80 → 0x3F800000, 0xBF800000, 0x00000000, 0x3C800000, 0xC0000000. `o_last` high only at index 31.
- NaN scale: scale 0xFF with random elements → all 32 outputs 0x7FC00000, `o_overflow`=0.
- Top of range: scale 254 with e0=0x80 and e1=0x7F → 0xFF800000 with `o_overflow`=1, then 0x7F7E0000 with `o_overflow`=0.
- Subnormal: scale 0 with e0=0x40 and e1=0xFF.
  - Macro defined → 0x00400000 and 0x80010000.
  - Macro undefined → 0x00000000 and 0x80000000.
- Backpressure: `i_ready` low for 3 cycles at index 5, with `i_valid` high throughout.
  - `o_float32` and `o_index`=5 stay stable; `o_ready`=0.
  - The second block is accepted only after index 31 completes, and its first output appears 1 cycle later.
- Reset mid-block: assert `i_rst` at index 10.
  - `o_valid`=0 immediately.
  - `o_ready`=1 in the first cycle after release.
  - The next block streams from index 0 with correct values.
